// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, reads instruction words from memory with a
// req/ack handshake and hands each word to the instruction register with a
// one-cycle load strobe. Handles stalls, redirects (also mid-fetch) and
// memory timeouts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_req,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_rd,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [31:0] o_ir_data,
    output logic        o_ir_load,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_busy,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2,
        ERR     = 2'd3
    } state_t;

    // Last REQ cycle without ack that is still tolerated before timing out.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_irData;
    logic [7:0]  r_waitCnt;
    logic        r_kill;
    logic [31:0] r_killPc;
    logic        w_redirAligned;
    logic        w_redirMisaligned;
    logic [31:0] w_pcPlus4;

    assign w_redirAligned    = i_redirect && (i_redirect_pc[1:0] == 2'b00);
    assign w_redirMisaligned = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign w_pcPlus4         = r_pc + 32'd4;

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a redirect arriving with the ack kills the data too.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_redirect) begin
                    w_nextState = w_redirMisaligned ? ERR : IDLE;
                end else if (i_fetch_req && !i_stall) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (w_redirMisaligned) begin
                    w_nextState = ERR;
                end else if (i_mem_ack) begin
                    w_nextState = (r_kill || i_redirect) ? IDLE : DELIVER;
                end else if (r_waitCnt == LP_WAIT_LAST) begin
                    w_nextState = ERR;
                end
            end
            DELIVER: begin
                if (i_redirect) begin
                    w_nextState = w_redirMisaligned ? ERR : IDLE;
                end else if (!i_stall) begin
                    w_nextState = IDLE;
                end
            end
            ERR: begin
                w_nextState = ERR;
            end
            default: begin
                w_nextState = ERR;
            end
        endcase
    end

    // Datapath: pc, fetched word, wait counter and the pending-redirect capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc      <= RESET_PC;
            r_irData  <= 32'd0;
            r_waitCnt <= 8'd0;
            r_kill    <= 1'b0;
            r_killPc  <= 32'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_redirAligned) begin
                        r_pc <= i_redirect_pc;
                    end else if (!i_redirect && i_fetch_req && !i_stall) begin
                        r_waitCnt <= 8'd0;
                        r_kill    <= 1'b0;
                    end
                end
                REQ: begin
                    if (i_mem_ack && !w_redirMisaligned) begin
                        if (i_redirect) begin
                            r_pc   <= i_redirect_pc;
                            r_kill <= 1'b0;
                        end else if (r_kill) begin
                            r_pc   <= r_killPc;
                            r_kill <= 1'b0;
                        end else begin
                            r_irData <= i_mem_rdata;
                        end
                    end else if (!i_mem_ack) begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                        if (w_redirAligned) begin
                            r_kill   <= 1'b1;
                            r_killPc <= i_redirect_pc;
                        end
                    end
                end
                DELIVER: begin
                    if (w_redirAligned) begin
                        r_pc <= i_redirect_pc;
                    end else if (!i_redirect && !i_stall) begin
                        r_pc <= w_pcPlus4;
                    end
                end
                ERR: begin
                    r_pc <= r_pc;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Outputs decoded from the current state; a reset cycle never loads the IR.
    always_comb begin
        o_mem_rd    = (r_state == REQ);
        o_ir_load   = (r_state == DELIVER) && !i_stall && !i_redirect && i_reset;
        o_busy      = (r_state != IDLE);
        o_fetch_err = (r_state == ERR);
    end

    assign o_mem_addr = r_pc;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pcPlus4;
    assign o_ir_data  = r_irData;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: per-cycle vector table plus a hand-written
// timeout sequence. Inputs change on the falling edge, outputs are sampled
// shortly after, well before the next rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchReq;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        memRd;
    logic [31:0] memAddr;
    logic [31:0] memRdata;
    logic        memAck;
    logic [31:0] irData;
    logic        irLoad;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        busy;
    logic        fetchErr;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic        rst;
        logic        fr;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        chk;
        logic        eMrd;
        logic        eLd;
        logic [31:0] eIr;
        logic [31:0] ePc;
        logic        eBusy;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    instr_fetch_unit #(
        .RESET_PC(32'h0000_3000),
        .MAX_WAIT(15)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_fetch_req  (fetchReq),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirectPc),
        .o_mem_rd     (memRd),
        .o_mem_addr   (memAddr),
        .i_mem_rdata  (memRdata),
        .i_mem_ack    (memAck),
        .o_ir_data    (irData),
        .o_ir_load    (irLoad),
        .o_pc         (pc),
        .o_pc_plus4   (pcPlus4),
        .o_busy       (busy),
        .o_fetch_err  (fetchErr)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic fr, input logic st,
                          input logic rd, input logic [31:0] rpc,
                          input logic ack, input logic [31:0] rdata,
                          input logic chk, input logic eMrd, input logic eLd,
                          input logic [31:0] eIr, input logic [31:0] ePc,
                          input logic eBusy, input logic eErr);
        vec_t v;
        v.rst = rst; v.fr = fr; v.st = st; v.rd = rd; v.rpc = rpc;
        v.ack = ack; v.rdata = rdata; v.chk = chk; v.eMrd = eMrd;
        v.eLd = eLd; v.eIr = eIr; v.ePc = ePc; v.eBusy = eBusy; v.eErr = eErr;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input int idx,
                            input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        fetchReq   = v.fr;
        stall      = v.st;
        redirect   = v.rd;
        redirectPc = v.rpc;
        memAck     = v.ack;
        memRdata   = v.rdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #2;
        if (v.chk) begin
            checkVal("mem_rd", idx, {31'd0, memRd}, {31'd0, v.eMrd});
            if (v.eMrd) checkVal("mem_addr", idx, memAddr, v.ePc);
            checkVal("ir_load", idx, {31'd0, irLoad}, {31'd0, v.eLd});
            checkVal("ir_data", idx, irData, v.eIr);
            checkVal("pc", idx, pc, v.ePc);
            checkVal("pc_plus4", idx, pcPlus4, v.ePc + 32'd4);
            checkVal("busy", idx, {31'd0, busy}, {31'd0, v.eBusy});
            checkVal("fetch_err", idx, {31'd0, fetchErr}, {31'd0, v.eErr});
        end
    endtask

    // Main sequence: vector table first, then the timeout scenario.
    initial begin
        int   reqCycles;
        logic gotErr;
        logic addrBad;

        reset = 1'b0; fetchReq = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirectPc = 32'd0; memAck = 1'b0; memRdata = 32'd0;

        //     rst fr st rd rpc           ack rdata         chk mrd ld ir            pc            busy err
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        // Basic fetch: two wait cycles then ack.
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0,        32'h0000_3000, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0,        32'h0000_3000, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'h8C01_0004, 1, 1, 0, 32'h0,        32'h0000_3000, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h8C01_0004, 32'h0000_3000, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h8C01_0004, 32'h0000_3004, 0, 0);
        // Stall held three cycles in DELIVER.
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h8C01_0004, 32'h0000_3004, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'h1234_5678, 1, 1, 0, 32'h8C01_0004, 32'h0000_3004, 1, 0);
        for (int i = 0; i < 3; i++)
            addVec(1, 0, 1, 0, 32'h0,    0, 32'h0,        1, 0, 0, 32'h1234_5678, 32'h0000_3004, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h1234_5678, 32'h0000_3004, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1234_5678, 32'h0000_3008, 0, 0);
        // Redirect during REQ, ack one cycle later.
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1234_5678, 32'h0000_3008, 0, 0);
        addVec(1, 0, 0, 1, 32'h0000_3040, 0, 32'h0,       1, 1, 0, 32'h1234_5678, 32'h0000_3008, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 1, 0, 32'h1234_5678, 32'h0000_3008, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1234_5678, 32'h0000_3040, 0, 0);
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1234_5678, 32'h0000_3040, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h1234_5678, 32'h0000_3040, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'h0000_0013, 1, 1, 0, 32'h1234_5678, 32'h0000_3040, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0000_0013, 32'h0000_3040, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_0013, 32'h0000_3044, 0, 0);
        // Reset from IDLE restores RESET_PC and clears ir_data.
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_0013, 32'h0000_3044, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        // Misaligned redirect in IDLE goes to ERR with pc unchanged.
        addVec(1, 0, 0, 1, 32'h0000_3042, 0, 32'h0,       1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        addVec(1, 1, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 1, 1);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 1, 1);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        // Redirect to the top word, then fetch: pc wraps to zero.
        addVec(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'h0000_AAAA, 1, 1, 0, 32'h0,        32'hFFFF_FFFC, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0000_AAAA, 32'hFFFF_FFFC, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_AAAA, 32'h0,        0, 0);
        // Reset asserted in the ack cycle.
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_AAAA, 32'h0,        0, 0);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'h5555_5555, 1, 1, 0, 32'h0000_AAAA, 32'h0,        1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        // Redirect while stalled in DELIVER drops the word.
        addVec(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000, 0, 0);
        addVec(1, 0, 0, 0, 32'h0,        1, 32'h1111_2222, 1, 1, 0, 32'h0,        32'h0000_3000, 1, 0);
        addVec(1, 0, 1, 1, 32'h0000_3100, 0, 32'h0,       1, 0, 0, 32'h1111_2222, 32'h0000_3000, 1, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1111_2222, 32'h0000_3100, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Timeout: no ack ever, expect exactly 15 REQ cycles before ERR.
        @(negedge clk);
        fetchReq = 1'b1;
        @(negedge clk);
        fetchReq = 1'b0;
        reqCycles = 0;
        gotErr    = 1'b0;
        addrBad   = 1'b0;
        for (int c = 0; c < 40 && !gotErr; c++) begin
            #2;
            if (fetchErr) begin
                gotErr = 1'b1;
            end else begin
                if (memRd) reqCycles++;
                if (memAddr !== 32'h0000_3100) addrBad = 1'b1;
                @(negedge clk);
            end
        end
        checkVal("timeout_reached", 0, {31'd0, gotErr}, 32'd1);
        checkVal("timeout_req_cycles", 0, reqCycles, 32'd15);
        checkVal("timeout_addr_bad", 0, {31'd0, addrBad}, 32'd0);

        // ERR ignores fetch_req and mem_ack.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            fetchReq = 1'b1;
            memAck   = 1'b1;
            #2;
            checkVal("err_mem_rd", c, {31'd0, memRd}, 32'd0);
            checkVal("err_flag", c, {31'd0, fetchErr}, 32'd1);
            checkVal("err_ir_load", c, {31'd0, irLoad}, 32'd0);
        end

        // Reset pulse clears the error and restores RESET_PC.
        @(negedge clk);
        fetchReq = 1'b0;
        memAck   = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        checkVal("post_reset_err", 0, {31'd0, fetchErr}, 32'd0);
        checkVal("post_reset_pc", 0, pc, 32'h0000_3000);
        checkVal("post_reset_busy", 0, {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
